// File: rtl/sipo_deser.sv
// -----------------------------------------------------------------------------
// sipo_deser -- serial-in / parallel-out deserializer.
//
// Collects WIDTH serial bits (qualified by sin_en) into one word and presents it
// on a registered valid/ready output.
//
// Parameters
//   WIDTH      bits per word (2..32)
//   MSB_FIRST  0: first received bit lands in dout[0]
//              1: first received bit lands in dout[WIDTH-1]
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous reset, active-high
//   start       begin (or restart) a frame, 1-cycle pulse
//   sin         serial data bit
//   sin_en      sin is valid this cycle
//   dout        last completed word (registered)
//   dout_valid  dout holds an unconsumed word
//   dout_ready  consumer accepts dout this cycle
//   busy        frame in progress
//   overrun     sticky: a completed word was dropped (cleared only by rst)
//   all_ones    &dout
// -----------------------------------------------------------------------------
module sipo_deser #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sin,
    input  logic             sin_en,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             busy,
    output logic             overrun,
    output logic             all_ones
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             dout_valid_q, dout_valid_d;
    logic             overrun_q, overrun_d;
    logic [WIDTH-1:0] word;
    logic             done;

    always_comb begin
        // Shift register with the current bit applied; on the final bit this
        // is the complete word, so it can go straight to dout on the same edge.
        if (MSB_FIRST) word = {sr_q[WIDTH-2:0], sin};
        else           word = {sin, sr_q[WIDTH-1:1]};

        state_d      = state_q;
        cnt_d        = cnt_q;
        sr_d         = sr_q;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        overrun_d    = overrun_q;
        done         = 1'b0;

        if (dout_valid_q && dout_ready) dout_valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    sr_d    = '0;
                end
            end
            SHIFT: begin
                // A restart wins over a bit arriving in the same cycle.
                if (start) begin
                    cnt_d = '0;
                    sr_d  = '0;
                end else if (sin_en) begin
                    sr_d = word;
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        done    = 1'b1;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Output slot is free if empty or being consumed on this edge;
        // otherwise the new word is lost and the sticky flag is raised.
        if (done) begin
            if (!dout_valid_q || dout_ready) begin
                dout_d       = word;
                dout_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            sr_q         <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sr_q         <= sr_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            overrun_q    <= overrun_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign busy       = (state_q == SHIFT);
    assign overrun    = overrun_q;
    assign all_ones   = &dout_q;

endmodule
